stopwatch_timer: RTL and testbench
==================================

Name: stopwatch_timer

Overview:
Parametrised successor to the team's single-mode 32-bit stopwatch. Adds four things:
- a prescaled count tick;
- count-up (stopwatch) and count-down (timer) modes with terminal detection;
- preload of the count;
- a lap-capture FIFO.

It sits between the debounced button/control logic and the seven-segment display formatter. The formatter reads either the live count or the lap head.

Parameters:
WIDTH, 32, counter and lap data width in bits (>=4)
PRESCALE, 1, clk cycles per count tick (>=1; 1 means count every cycle)
LAP_DEPTH, 4, lap FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  level/pulse; begin or resume counting
stop  input  1  pause counting
clear  input  1  zero the count, halt, flush laps, clear flags
mode  input  1  0 = count up, 1 = count down; latched on accepted start
load_en  input  1  load count from load_val (only when halted)
load_val  input  WIDTH  preload value
lap  input  1  capture current count into lap FIFO
lap_rd  input  1  pop lap FIFO head
count  output  WIDTH  current count
running  output  1  counting active
expired  output  1  sticky terminal flag
lap_valid  output  1  FIFO non-empty
lap_data  output  WIDTH  FIFO head (first-word fall-through)
lap_full  output  1  FIFO holds LAP_DEPTH entries
lap_overflow  output  1  sticky; a lap was dropped while full

Behaviour:
- Reset (rst_n=0 at an edge): all outputs 0; internal state 0, including the prescaler, latched mode, and FIFO pointers/occupancy. Reset overrides every other input.
- Control priority per edge: clear > stop > start.
  - clear: count=0, running=0, prescaler=0, expired=0, lap_overflow=0, FIFO emptied. The same-edge lap and lap_rd are ignored.
  - stop: running=0. The prescaler holds its value, so a pause preserves the fractional tick.
  - start (with running=0): running=1 and mode_q=mode.
    - Ignored if latched-down mode would start at count==0.
    - Ignored if expired=1; the flag must first be cleared by clear or load.
  - start with running=1: no effect. The mode input is not re-sampled.
- load_en with running=0 and no clear: count=load_val and expired=0. Ignored when running=1.
- Tick: tick = running_q && (presc == PRESCALE-1). running_q is the value before the edge.
  - running=1 set at edge N enables the first prescaler advance at edge N+1.
  - The prescaler increments each edge while running_q=1 and wraps to 0 on tick.
  - With PRESCALE=1, count changes at edge N+1.
- Count update on tick:
  - mode_q=0: count+1. If count was all-ones, count holds all-ones (saturate), expired=1, running=0.
  - mode_q=1: count-1. When the result reaches 0, expired=1 and running=0 on the same edge. No underflow ever occurs.
- stop or clear on the same edge as a tick: the control wins. clear zeroes the count; stop suppresses that edge's count update.
- Lap push: lap=1 with running_q=1 pushes the pre-edge count value. Lap while halted is ignored.
- Lap pop: lap_rd=1 with lap_valid=1 pops. lap_rd while empty is ignored.
- Lap FIFO boundaries:
  - Push while full without a pop: the entry is dropped and lap_overflow=1.
  - Push and pop on the same edge: both are performed, and occupancy is unchanged, including when full.
  - Push into an empty FIFO: lap_valid=1 and lap_data valid the next cycle.
- Registered outputs:
  - lap_full = (occupancy == LAP_DEPTH).
  - lap_data is undefined-but-stable when lap_valid=0; drive 0.
- Mid-operation reset: everything returns to reset values at that edge. FIFO contents are discarded.

Test Plan:
- Reset, then start pulse, PRESCALE=1, mode=0 → running=1 after edge 1; count=1 after edge 2; count=10 after edge 11. stop → count frozen at its value; start again resumes from it.
- PRESCALE=4, mode=1, load_val=3, load_en, start → count 3→2→1→0 on ticks every 4 cycles. On the edge reaching 0: expired=1, running=0. A further start is ignored until clear.
- WIDTH=4, load 14, mode=0, start → count 15, holds 15, expired=1, running=0. load_en with 5 → count=5, expired=0.
- Running, lap pulses at count=3,7,12 → lap_data=3, lap_valid=1. lap_rd pops give 7, then 12, then lap_valid=0.
- LAP_DEPTH=4, five laps without reads → lap_full=1, lap_overflow=1, the first four values retained. Lap plus lap_rd on the same edge while full → occupancy stays 4, head advances.
- Same-edge start+stop → running stays 0. Same-edge clear+lap while running → count=0, FIFO empty, no push. rst_n=0 mid-count → all outputs 0 next edge.

Source files
------------

// File: rtl/stopwatch_timer.sv
// Prescaled up/down stopwatch/timer with preload, terminal detection and a lap-capture FIFO.
// All state is updated on the rising clock edge; rst_n is a synchronous active-low reset.
module stopwatch_timer #(
    parameter int WIDTH     = 32,
    parameter int PRESCALE  = 1,
    parameter int LAP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             mode,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             lap,
    input  logic             lap_rd,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             lap_valid,
    output logic [WIDTH-1:0] lap_data,
    output logic             lap_full,
    output logic             lap_overflow
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int AW = $clog2(LAP_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [OW-1:0] OCC_FULL   = OW'(LAP_DEPTH);

    logic [WIDTH-1:0] r_count;
    logic             r_running;
    logic             r_mode;
    logic             r_expired;
    logic [PW-1:0]    r_presc;

    logic [WIDTH-1:0] r_mem [LAP_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [OW-1:0]    r_occ;
    logic             r_overflow;

    logic w_tick;
    logic w_start_ok;
    logic w_not_empty;
    logic w_full;
    logic w_push_req;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_tick      = r_running && (r_presc == PRESC_LAST);
    // A down-count may not begin at zero, and an expired count must be cleared or reloaded first.
    assign w_start_ok  = start && !r_running && !r_expired && !(mode && (r_count == '0));

    assign w_not_empty = (r_occ != '0);
    assign w_full      = (r_occ == OCC_FULL);
    assign w_push_req  = lap && r_running && !clear;
    assign w_pop       = lap_rd && w_not_empty && !clear;
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_drop      = w_push_req && w_full && !w_pop;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_running <= 1'b0;
            r_mode    <= 1'b0;
            r_expired <= 1'b0;
            r_presc   <= '0;
        end else if (clear) begin
            r_count   <= '0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_presc   <= '0;
        end else begin
            if (stop) begin
                r_running <= 1'b0;
            end else if (w_start_ok) begin
                r_running <= 1'b1;
                r_mode    <= mode;
            end else if (w_tick) begin
                if (!r_mode) begin
                    if (r_count == '1) begin
                        r_expired <= 1'b1;
                        r_running <= 1'b0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end else begin
                    r_count <= r_count - 1'b1;
                    if (r_count == WIDTH'(1)) begin
                        r_expired <= 1'b1;
                        r_running <= 1'b0;
                    end
                end
            end
            // Stop freezes the prescaler so a pause keeps the partial tick.
            if (r_running && !stop) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end
            if (load_en && !r_running) begin
                r_count   <= load_val;
                r_expired <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
            else if (w_pop && !w_push) r_occ <= r_occ - 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // NOTE: lap storage carries no reset; occupancy gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_count;
    end

    assign count        = r_count;
    assign running      = r_running;
    assign expired      = r_expired;
    assign lap_valid    = w_not_empty;
    assign lap_full     = w_full;
    assign lap_overflow = r_overflow;
    assign lap_data     = w_not_empty ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench for stopwatch_timer: a vector table on the default configuration plus
// hand sequences for prescaled countdown, 4-bit saturation and mid-count reset.
module tb_stopwatch_timer;

    logic        clk;
    logic        rst_n;
    logic        start, stop, clear, mode, load_en, lap, lap_rd;
    logic [31:0] load_val;

    logic [31:0] m_count, m_lap_data;
    logic        m_running, m_expired, m_lap_valid, m_lap_full, m_lap_overflow;
    logic [7:0]  p_count, p_lap_data;
    logic        p_running, p_expired, p_lap_valid, p_lap_full, p_lap_overflow;
    logic [3:0]  w_count, w_lap_data;
    logic        w_running, w_expired, w_lap_valid, w_lap_full, w_lap_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_timer #(.WIDTH(32), .PRESCALE(1), .LAP_DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .mode(mode),
        .load_en(load_en), .load_val(load_val), .lap(lap), .lap_rd(lap_rd),
        .count(m_count), .running(m_running), .expired(m_expired), .lap_valid(m_lap_valid),
        .lap_data(m_lap_data), .lap_full(m_lap_full), .lap_overflow(m_lap_overflow)
    );

    stopwatch_timer #(.WIDTH(8), .PRESCALE(4), .LAP_DEPTH(4)) u_p4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .mode(mode),
        .load_en(load_en), .load_val(load_val[7:0]), .lap(lap), .lap_rd(lap_rd),
        .count(p_count), .running(p_running), .expired(p_expired), .lap_valid(p_lap_valid),
        .lap_data(p_lap_data), .lap_full(p_lap_full), .lap_overflow(p_lap_overflow)
    );

    stopwatch_timer #(.WIDTH(4), .PRESCALE(1), .LAP_DEPTH(2)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .mode(mode),
        .load_en(load_en), .load_val(load_val[3:0]), .lap(lap), .lap_rd(lap_rd),
        .count(w_count), .running(w_running), .expired(w_expired), .lap_valid(w_lap_valid),
        .lap_data(w_lap_data), .lap_full(w_lap_full), .lap_overflow(w_lap_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st, sp, cl, md, ld;
        logic [31:0] lv;
        logic        lp, rd;
        logic [31:0] ec;
        logic        er, ee, ev;
        logic [31:0] ed;
        logic        ef, eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic st, input logic sp, input logic cl, input logic md,
                               input logic ld, input logic [31:0] lv, input logic lp,
                               input logic rd, input logic [31:0] ec, input logic er,
                               input logic ee, input logic ev, input logic [31:0] ed,
                               input logic ef, input logic eo);
        vec_t r;
        r.st = st; r.sp = sp; r.cl = cl; r.md = md; r.ld = ld; r.lv = lv; r.lp = lp; r.rd = rd;
        r.ec = ec; r.er = er; r.ee = ee; r.ev = ev; r.ed = ed; r.ef = ef; r.eo = eo;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic sp, input logic cl, input logic md,
                         input logic ld, input logic [31:0] lv, input logic lp, input logic rd);
        start = st; stop = sp; clear = cl; mode = md; load_en = ld; load_val = lv;
        lap = lp; lap_rd = rd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_main_zero(input string tag);
        check({tag, ".count"},        m_count, 0);
        check({tag, ".running"},      32'(m_running), 0);
        check({tag, ".expired"},      32'(m_expired), 0);
        check({tag, ".lap_valid"},    32'(m_lap_valid), 0);
        check({tag, ".lap_data"},     m_lap_data, 0);
        check({tag, ".lap_full"},     32'(m_lap_full), 0);
        check({tag, ".lap_overflow"}, 32'(m_lap_overflow), 0);
    endtask

    initial begin
        // Up-count, pause and resume.
        vecs.push_back(v(1,0,0,0,0,0,0,0,  0,1,0,0,0,0,0));
        for (int i = 1; i <= 10; i++) vecs.push_back(v(0,0,0,0,0,0,0,0, i,1,0,0,0,0,0));
        vecs.push_back(v(0,1,0,0,0,0,0,0, 10,0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0, 10,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0, 10,1,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0, 11,1,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0, 12,1,0,0,0,0,0));
        vecs.push_back(v(0,1,0,0,0,0,0,0, 12,0,0,0,0,0,0));
        // Laps at 3, 7, 12 then drain.
        vecs.push_back(v(0,0,1,0,0,0,0,0,  0,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0,  0,1,0,0,0,0,0));
        for (int i = 1; i <= 3; i++) vecs.push_back(v(0,0,0,0,0,0,0,0, i,1,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1,0,  4,1,0,1,3,0,0));
        for (int i = 5; i <= 7; i++) vecs.push_back(v(0,0,0,0,0,0,0,0, i,1,0,1,3,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1,0,  8,1,0,1,3,0,0));
        for (int i = 9; i <= 12; i++) vecs.push_back(v(0,0,0,0,0,0,0,0, i,1,0,1,3,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1,0, 13,1,0,1,3,0,0));
        vecs.push_back(v(0,1,0,0,0,0,0,0, 13,0,0,1,3,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1,0, 13,0,0,1,3,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,1, 13,0,0,1,7,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,1, 13,0,0,1,12,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,1, 13,0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,1, 13,0,0,0,0,0,0));
        // Fill, overflow, simultaneous push/pop while full, clear with lap.
        vecs.push_back(v(0,0,1,0,0,0,0,0,  0,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0,  0,1,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1,0,  1,1,0,1,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1,0,  2,1,0,1,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1,0,  3,1,0,1,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1,0,  4,1,0,1,0,1,0));
        vecs.push_back(v(0,0,0,0,0,0,1,0,  5,1,0,1,0,1,1));
        vecs.push_back(v(0,0,0,0,0,0,1,1,  6,1,0,1,1,1,1));
        vecs.push_back(v(0,0,0,0,0,0,0,1,  7,1,0,1,2,0,1));
        vecs.push_back(v(0,0,0,0,0,0,0,1,  8,1,0,1,3,0,1));
        vecs.push_back(v(0,0,1,0,0,0,1,0,  0,0,0,0,0,0,0));
        // Start corner cases, load rules and down-count expiry.
        vecs.push_back(v(1,1,0,0,0,0,0,0,  0,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,1,0,0,0,0,  0,0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,1,5,0,0,  5,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,1,0,0,0,0,  5,1,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,  4,1,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,1,100,0,0, 3,1,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0,  2,1,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,  1,1,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,  0,0,1,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0,  0,0,1,0,0,0,0));
        vecs.push_back(v(0,0,0,0,1,2,0,0,  2,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,0,  2,1,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,  3,1,0,0,0,0,0));

        rst_n = 1'b0;
        idle();
        step();
        step();
        check_main_zero("reset");
        check("reset.p4_count", 32'(p_count), 0);
        check("reset.w4_count", 32'(w_count), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].md, vecs[i].ld, vecs[i].lv,
                  vecs[i].lp, vecs[i].rd);
            step();
            check($sformatf("vec%0d.count", i),        m_count, vecs[i].ec);
            check($sformatf("vec%0d.running", i),      32'(m_running), 32'(vecs[i].er));
            check($sformatf("vec%0d.expired", i),      32'(m_expired), 32'(vecs[i].ee));
            check($sformatf("vec%0d.lap_valid", i),    32'(m_lap_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d.lap_data", i),     m_lap_data, vecs[i].ed);
            check($sformatf("vec%0d.lap_full", i),     32'(m_lap_full), 32'(vecs[i].ef));
            check($sformatf("vec%0d.lap_overflow", i), 32'(m_lap_overflow), 32'(vecs[i].eo));
        end

        // PRESCALE=4 countdown from 3: one tick every four edges after start.
        drive(0, 0, 1, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 3, 0, 0); step();
        check("p4.load", 32'(p_count), 3);
        drive(1, 0, 0, 1, 0, 0, 0, 0); step();
        check("p4.start_running", 32'(p_running), 1);
        idle();
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("p4.k%0d.count", k),   32'(p_count), 32'(3 - k / 4));
            check($sformatf("p4.k%0d.running", k), 32'(p_running), 32'(k < 12));
            check($sformatf("p4.k%0d.expired", k), 32'(p_expired), 32'(k == 12));
        end
        drive(1, 0, 0, 1, 0, 0, 0, 0); step();
        check("p4.restart_ignored", 32'(p_running), 0);
        check("p4.still_expired", 32'(p_expired), 1);
        drive(0, 0, 1, 0, 0, 0, 0, 0); step();
        check("p4.clear_expired", 32'(p_expired), 0);

        // Pause keeps the partial prescaler count.
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        idle(); step(); step();
        drive(0, 1, 0, 0, 0, 0, 0, 0); step();
        check("p4.pause_count", 32'(p_count), 0);
        check("p4.pause_running", 32'(p_running), 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        check("p4.resume_running", 32'(p_running), 1);
        idle(); step();
        check("p4.resume_k1", 32'(p_count), 0);
        step();
        check("p4.resume_k2", 32'(p_count), 1);

        // WIDTH=4 saturation at all-ones.
        drive(0, 0, 1, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 14, 0, 0); step();
        check("w4.load", 32'(w_count), 14);
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        check("w4.start_count", 32'(w_count), 14);
        idle(); step();
        check("w4.count15", 32'(w_count), 15);
        check("w4.running_at15", 32'(w_running), 1);
        step();
        check("w4.sat_count", 32'(w_count), 15);
        check("w4.sat_expired", 32'(w_expired), 1);
        check("w4.sat_running", 32'(w_running), 0);
        step();
        check("w4.hold_count", 32'(w_count), 15);
        drive(0, 0, 0, 0, 1, 5, 0, 0); step();
        check("w4.reload_count", 32'(w_count), 5);
        check("w4.reload_expired", 32'(w_expired), 0);

        // Reset in the middle of counting with a non-empty lap FIFO.
        drive(0, 0, 1, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        idle(); step();
        drive(0, 0, 0, 0, 0, 0, 1, 0); step();
        check("midrst.pre_valid", 32'(m_lap_valid), 1);
        check("midrst.pre_count", m_count, 2);
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b0;
        step();
        check_main_zero("midrst");
        check("midrst.p4_running", 32'(p_running), 0);
        check("midrst.w4_count", 32'(w_count), 0);
        rst_n = 1'b1;
        idle(); step();
        check("postrst.count", m_count, 0);
        check("postrst.running", 32'(m_running), 0);
        check("postrst.lap_valid", 32'(m_lap_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
